// File: rtl/fifo_byte_serializer.sv
// Pops words from a synchronous FIFO and streams them out as byte_width beats, LS beat first.
// Beat 0 is valid two cycles after the pop; a stalled beat holds until out_ready, and the next pop rides the final handshake.
module fifo_byte_serializer #(
  parameter int data_width = 32,
  parameter int byte_width = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  EN,
  input  logic                  fifo_empty,
  input  logic [data_width-1:0] fifo_data,
  output logic                  fifo_rd_en,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [byte_width-1:0] out_data,
  output logic                  out_last,
  output logic                  busy,
  output logic [15:0]           word_count
);

  localparam int NB    = data_width / byte_width;
  localparam int IDX_W = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NB - 1);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SEND
  } state_t;

  state_t                state_q, state_d;
  logic [data_width-1:0] shreg_q, shreg_d;
  logic [IDX_W-1:0]      beat_idx_q, beat_idx_d;
  logic [IDX_W-1:0]      beat_nxt;
  logic                  out_valid_q, out_valid_d;
  logic [byte_width-1:0] out_data_q, out_data_d;
  logic                  out_last_q, out_last_d;
  logic                  busy_q, busy_d;
  logic [15:0]           word_count_q, word_count_d;
  logic                  hs;
  logic                  word_done;

  // Pop is gated by reset so a held reset with a non-empty FIFO never drains it.
  always_comb begin
    beat_nxt   = beat_idx_q + IDX_W'(1);
    hs         = out_valid_q && out_ready;
    word_done  = (state_q == SEND) && hs && (beat_idx_q == LAST_IDX);
    fifo_rd_en = reset_n && EN && !fifo_empty && ((state_q == IDLE) || word_done);
  end

  always_comb begin
    state_d      = state_q;
    shreg_d      = shreg_q;
    beat_idx_d   = beat_idx_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_last_d   = out_last_q;
    word_count_d = word_count_q;
    case (state_q)
      IDLE: begin
        out_valid_d = 1'b0;
        if (fifo_rd_en) begin
          state_d = LOAD;
        end
      end
      LOAD: begin
        shreg_d     = fifo_data;
        beat_idx_d  = '0;
        out_valid_d = 1'b1;
        out_data_d  = fifo_data[byte_width-1:0];
        out_last_d  = 1'b0;
        state_d     = SEND;
      end
      SEND: begin
        if (hs) begin
          if (beat_idx_q == LAST_IDX) begin
            word_count_d = word_count_q + 16'd1;
            out_valid_d  = 1'b0;
            out_last_d   = 1'b0;
            state_d      = fifo_rd_en ? LOAD : IDLE;
          end else begin
            beat_idx_d = beat_nxt;
            out_data_d = shreg_q[beat_nxt*byte_width +: byte_width];
            out_last_d = (beat_nxt == LAST_IDX);
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      shreg_q      <= '0;
      beat_idx_q   <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_last_q   <= 1'b0;
      busy_q       <= 1'b0;
      word_count_q <= '0;
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      beat_idx_q   <= beat_idx_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_last_q   <= out_last_d;
      busy_q       <= busy_d;
      word_count_q <= word_count_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_last   = out_last_q;
  assign busy       = busy_q;
  assign word_count = word_count_q;

endmodule
